// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding scoreboard for a 5-stage F/D/E/M/W pipeline.
// Tracks E/M/W destination tags internally and produces forward selects plus stall/flush controls.

module hs_src_lane #(
    parameter int              AW     = 4,
    parameter int              FWD_EN = 1,
    parameter logic [AW-1:0]   PC_IDX = {AW{1'b1}}
) (
    input  logic          d_src_valid,
    input  logic [AW-1:0] d_src_ra,
    input  logic          e_src_valid,
    input  logic [AW-1:0] e_src_ra,
    input  logic          e_valid,
    input  logic [AW-1:0] e_wa,
    input  logic          m_valid,
    input  logic [AW-1:0] m_wa,
    input  logic          w_valid,
    input  logic [AW-1:0] w_wa,
    output logic [1:0]    fwd_sel,
    output logic          hz_e,
    output logic          hz_m
);
    logic d_ok, e_ok, fwd_m, fwd_w;

    // The PC index is excluded from matching so PC reads are never bypassed or interlocked.
    assign d_ok  = d_src_valid && (d_src_ra != PC_IDX);
    assign e_ok  = e_src_valid && (e_src_ra != PC_IDX);
    assign hz_e  = d_ok && e_valid && (d_src_ra == e_wa);
    assign hz_m  = d_ok && m_valid && (d_src_ra == m_wa);
    assign fwd_m = e_ok && m_valid && (e_src_ra == m_wa);
    assign fwd_w = e_ok && w_valid && (e_src_ra == w_wa);

    always_comb begin
        fwd_sel = 2'b00;
        if (FWD_EN != 0) begin
            if (fwd_m)      fwd_sel = 2'b10;
            else if (fwd_w) fwd_sel = 2'b01;
        end
    end
endmodule

module hazard_scoreboard #(
    parameter int            AW     = 4,
    parameter int            NSRC   = 2,
    parameter int            FWD_EN = 1,
    parameter logic [AW-1:0] PC_IDX = {AW{1'b1}},
    parameter int            CW     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC-1:0]      src_valid_d,
    input  logic [NSRC*AW-1:0]   src_ra_d,
    input  logic                 dst_valid_d,
    input  logic [AW-1:0]        dst_wa_d,
    input  logic                 is_load_d,
    input  logic                 pcsrc_d,
    input  logic                 branch_taken_d,
    output logic [2*NSRC-1:0]    fwd_sel_e,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic [CW-1:0]        stall_count
);
    localparam int STAGES = 3;  // 1 = E, 2 = M, 3 = W

    logic [STAGES:1]         vld_pipe;
    logic [STAGES:1]         pcs_pipe;
    logic [STAGES:1][AW-1:0] wa_pipe;
    logic                    e_is_load;
    logic [NSRC-1:0]         e_src_valid;
    logic [NSRC*AW-1:0]      e_src_ra;

    logic [NSRC-1:0]         hz_e, hz_m;
    logic [2*NSRC-1:0]       fwd_sel;
    logic                    ldstall, pend;

    for (genvar i = 0; i < NSRC; i++) begin : g_lane
        hs_src_lane #(.AW(AW), .FWD_EN(FWD_EN), .PC_IDX(PC_IDX)) u_lane (
            .d_src_valid (src_valid_d[i]),
            .d_src_ra    (src_ra_d[i*AW +: AW]),
            .e_src_valid (e_src_valid[i]),
            .e_src_ra    (e_src_ra[i*AW +: AW]),
            .e_valid     (vld_pipe[1]),
            .e_wa        (wa_pipe[1]),
            .m_valid     (vld_pipe[2]),
            .m_wa        (wa_pipe[2]),
            .w_valid     (vld_pipe[3]),
            .w_wa        (wa_pipe[3]),
            .fwd_sel     (fwd_sel[2*i +: 2]),
            .hz_e        (hz_e[i]),
            .hz_m        (hz_m[i])
        );
    end

    // Without bypassing, a producer in E or M must drain; W is covered by the write-through regfile.
    assign ldstall = (FWD_EN != 0) ? (e_is_load && (|hz_e)) : ((|hz_e) || (|hz_m));
    assign pend    = pcsrc_d || pcs_pipe[1] || pcs_pipe[2];

    assign stall_d   = !reset && ldstall;
    assign stall_f   = !reset && (ldstall || pend);
    assign flush_e   = reset || ldstall || branch_taken_d;
    assign flush_d   = reset || pend || pcs_pipe[3] || branch_taken_d;
    assign fwd_sel_e = reset ? '0 : fwd_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe    <= '0;
            pcs_pipe    <= '0;
            wa_pipe     <= '0;
            e_is_load   <= 1'b0;
            e_src_valid <= '0;
            e_src_ra    <= '0;
            stall_count <= '0;
        end else begin
            wa_pipe[1] <= dst_wa_d;
            e_src_ra   <= src_ra_d;
            if (flush_e) begin
                vld_pipe[1] <= 1'b0;
                pcs_pipe[1] <= 1'b0;
                e_is_load   <= 1'b0;
                e_src_valid <= '0;
            end else begin
                vld_pipe[1] <= dst_valid_d;
                pcs_pipe[1] <= pcsrc_d;
                e_is_load   <= is_load_d;
                e_src_valid <= src_valid_d;
            end
            vld_pipe[STAGES:2] <= vld_pipe[STAGES-1:1];
            pcs_pipe[STAGES:2] <= pcs_pipe[STAGES-1:1];
            wa_pipe[STAGES:2]  <= wa_pipe[STAGES-1:1];
            if (stall_d && (stall_count != '1))
                stall_count <= stall_count + CW'(1);
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: bypass, interlock and saturating-counter variants of hazard_scoreboard share one stimulus stream.

module tb_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] src_valid_d;
    logic [7:0] src_ra_d;
    logic       dst_valid_d;
    logic [3:0] dst_wa_d;
    logic       is_load_d, pcsrc_d, branch_taken_d;

    logic [3:0]  b_fwd, i_fwd, s_fwd;
    logic        b_sf, b_sd, b_fd, b_fe;
    logic        i_sf, i_sd, i_fd, i_fe;
    logic        s_sf, s_sd, s_fd, s_fe;
    logic [15:0] b_cnt, i_cnt;
    logic [1:0]  s_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.FWD_EN(1)) u_byp (
        .clk(clk), .reset(reset), .src_valid_d(src_valid_d), .src_ra_d(src_ra_d),
        .dst_valid_d(dst_valid_d), .dst_wa_d(dst_wa_d), .is_load_d(is_load_d),
        .pcsrc_d(pcsrc_d), .branch_taken_d(branch_taken_d), .fwd_sel_e(b_fwd),
        .stall_f(b_sf), .stall_d(b_sd), .flush_d(b_fd), .flush_e(b_fe), .stall_count(b_cnt)
    );

    hazard_scoreboard #(.FWD_EN(0)) u_ilk (
        .clk(clk), .reset(reset), .src_valid_d(src_valid_d), .src_ra_d(src_ra_d),
        .dst_valid_d(dst_valid_d), .dst_wa_d(dst_wa_d), .is_load_d(is_load_d),
        .pcsrc_d(pcsrc_d), .branch_taken_d(branch_taken_d), .fwd_sel_e(i_fwd),
        .stall_f(i_sf), .stall_d(i_sd), .flush_d(i_fd), .flush_e(i_fe), .stall_count(i_cnt)
    );

    hazard_scoreboard #(.FWD_EN(1), .CW(2)) u_sat (
        .clk(clk), .reset(reset), .src_valid_d(src_valid_d), .src_ra_d(src_ra_d),
        .dst_valid_d(dst_valid_d), .dst_wa_d(dst_wa_d), .is_load_d(is_load_d),
        .pcsrc_d(pcsrc_d), .branch_taken_d(branch_taken_d), .fwd_sel_e(s_fwd),
        .stall_f(s_sf), .stall_d(s_sd), .flush_d(s_fd), .flush_e(s_fe), .stall_count(s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [1:0] sv, input logic [3:0] ra0, input logic [3:0] ra1,
                       input logic dv, input logic [3:0] wa, input logic ld,
                       input logic pcs, input logic br);
        src_valid_d    = sv;
        src_ra_d       = {ra1, ra0};
        dst_valid_d    = dv;
        dst_wa_d       = wa;
        is_load_d      = ld;
        pcsrc_d        = pcs;
        branch_taken_d = br;
        #1;
    endtask

    task automatic idle();
        drv(2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input string tag, input logic sf, input logic sd, input logic fd, input logic fe);
        chk(tag, {b_sf, b_sd, b_fd, b_fe}, {sf, sd, fd, fe});
    endtask

    initial begin
        reset = 1'b1;
        idle();
        ctl("reset_ctl", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("reset_fwd", b_fwd, 4'b0000);
        tick();
        tick();
        chk("reset_cnt", b_cnt, 16'd0);
        reset = 1'b0;

        // Bypass from M: ADD r1,r2,r3 ; SUB r2,r1,r3
        drv(2'b11, 4'h2, 4'h3, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        ctl("add_ctl", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drv(2'b11, 4'h1, 4'h3, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
        chk("sub_nostall", b_sd, 1'b0);
        tick();
        idle();
        chk("fwd_from_m", b_fwd, 4'b0010);
        tick();

        // Bypass from W with one unrelated instruction in between
        drv(2'b11, 4'h2, 4'h3, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        tick();
        drv(2'b11, 4'h7, 4'h8, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
        tick();
        drv(2'b01, 4'h1, 4'h0, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
        chk("w_use_nostall", b_sd, 1'b0);
        tick();
        idle();
        chk("fwd_from_w", b_fwd, 4'b0001);
        tick();

        // r1 written in both M and W: M wins on both operands
        drv(2'b11, 4'ha, 4'hb, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        tick();
        drv(2'b11, 4'ha, 4'hb, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        tick();
        drv(2'b11, 4'h1, 4'h1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        chk("fwd_m_priority", b_fwd, 4'b1010);
        tick();

        // Load-use: LDR r1 ; ADD r4,r1,r5
        drv(2'b01, 4'h2, 4'h0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0);
        tick();
        drv(2'b11, 4'h1, 4'h5, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
        ctl("ldu_stall", 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        ctl("ldu_release", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ldu_cnt", b_cnt, 16'd1);
        tick();
        idle();
        chk("ldu_fwd_w", b_fwd, 4'b0001);
        tick();

        // Load targeting the PC index never hazards or forwards
        drv(2'b01, 4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
        tick();
        drv(2'b11, 4'hF, 4'hF, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
        chk("pcidx_nostall", b_sd, 1'b0);
        tick();
        idle();
        chk("pcidx_nofwd_m", b_fwd, 4'b0000);
        tick();
        chk("pcidx_nofwd_w", b_fwd, 4'b0000);
        tick();

        // PC write: stall_f for D,E,M; flush_d for D,E,M,W
        drv(2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        ctl("pc_d", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        ctl("pc_e", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        ctl("pc_m", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        ctl("pc_w", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        ctl("pc_done", 1'b0, 1'b0, 1'b0, 1'b0);

        // Taken branch flushes D and E
        drv(2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        ctl("branch", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();

        // Load-use coinciding with a taken branch
        drv(2'b01, 4'h2, 4'h0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0);
        tick();
        drv(2'b01, 4'h1, 4'h0, 1'b1, 4'h4, 1'b0, 1'b0, 1'b1);
        ctl("ldu_branch", 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        chk("ldu_branch_cnt", b_cnt, 16'd2);
        tick();

        // Reset asserted mid-stall
        drv(2'b01, 4'h2, 4'h0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0);
        tick();
        drv(2'b01, 4'h1, 4'h0, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_stall", b_sd, 1'b1);
        reset = 1'b1;
        #1;
        ctl("mid_reset_ctl", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("mid_reset_fwd", b_fwd, 4'b0000);
        tick();
        reset = 1'b0;
        drv(2'b01, 4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("post_reset_cnt", b_cnt, 16'd0);
        chk("post_reset_fwd", b_fwd, 4'b0000);
        ctl("post_reset_ctl", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Interlock variant: ADD r1 then use of r1 stalls twice
        drv(2'b11, 4'h2, 4'h3, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        chk("ilk_add", i_sd, 1'b0);
        tick();
        drv(2'b01, 4'h1, 4'h0, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
        chk("ilk_stall_e", {i_sf, i_sd, i_fe}, 3'b111);
        chk("ilk_byp_nostall", b_sd, 1'b0);
        tick();
        chk("ilk_stall_m", i_sd, 1'b1);
        chk("ilk_fwd_0", i_fwd, 4'b0000);
        tick();
        chk("ilk_release", i_sd, 1'b0);
        chk("ilk_cnt", i_cnt, 16'd2);
        tick();
        idle();
        chk("ilk_fwd_1", i_fwd, 4'b0000);
        tick();

        // Two-bit counter saturates at 3 over five load-use stalls
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            drv(2'b01, 4'h2, 4'h0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0);
            tick();
            drv(2'b01, 4'h1, 4'h0, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
            chk($sformatf("sat_stall_%0d", k), s_sd, 1'b1);
            tick();
            chk($sformatf("sat_cnt_%0d", k), s_cnt, (k < 3) ? k : 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
